conv_pixel_feeder: RTL and testbench

- Source end of the conv engine pixel-stream interface. Drives `start_signal`, `pixel_in` and `pixel_valid` into the 2D conv engine, and consumes its `done_signal`.
- Holds one IMG_WIDTH x IMG_HEIGHT 8-bit frame in local RAM, loaded through a simple write port.
- On `launch`: pulses start, streams the frame in raster order at a configurable pixel rate, waits for the engine's done, then reports frame completion.

---
 rtl/conv_pixel_feeder_pkg.sv | 20 ++
 rtl/conv_pixel_feeder_if.sv | 30 +++
 rtl/conv_pixel_feeder_frame_ram.sv | 32 +++
 rtl/conv_pixel_feeder.sv | 151 +++++++++++++++
 tb/tb_conv_pixel_feeder.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/conv_pixel_feeder_pkg.sv
// rtl/conv_pixel_feeder_pkg.sv - shared frame geometry, address type and feeder FSM states
package conv_feeder_pkg;

  localparam int IMG_WIDTH    = 32;
  localparam int IMG_HEIGHT   = 32;
  localparam int PIXEL_W      = 8;
  localparam int FRAME_PIXELS = IMG_WIDTH * IMG_HEIGHT;
  localparam int ADDR_W       = $clog2(FRAME_PIXELS);

  typedef logic [ADDR_W-1:0] frame_addr_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    STREAM,
    WAIT_DONE,
    FINISH
  } feeder_state_t;

endpackage

// File: rtl/conv_pixel_feeder_if.sv
// rtl/conv_pixel_feeder_if.sv - frame load, launch control and engine pixel-stream signals
interface conv_pixel_feeder_if #(
  parameter int PIXEL_W = 8,
  parameter int ADDR_W  = 10
);

  logic               load_we;
  logic [ADDR_W-1:0]  load_addr;
  logic [PIXEL_W-1:0] load_data;
  logic               launch;
  logic [3:0]         gap_cfg;
  logic               start_signal;
  logic [PIXEL_W-1:0] pixel_out;
  logic               pixel_valid;
  logic               engine_done;
  logic               busy;
  logic               frame_done;
  logic               timeout_err;

  modport master (
    input  load_we, load_addr, load_data, launch, gap_cfg, engine_done,
    output start_signal, pixel_out, pixel_valid, busy, frame_done, timeout_err
  );

  modport slave (
    output load_we, load_addr, load_data, launch, gap_cfg, engine_done,
    input  start_signal, pixel_out, pixel_valid, busy, frame_done, timeout_err
  );

endinterface

// File: rtl/conv_pixel_feeder_frame_ram.sv
// rtl/conv_pixel_feeder_frame_ram.sv - simple dual-port frame RAM, 1-cycle synchronous read
module feeder_frame_ram #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 8,
  parameter int AW     = 10
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  input  logic              i_rd_clr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Only the read register is cleared; stored pixels survive a reset.
  always_ff @(posedge clk) begin
    if (i_rd_clr)  r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/conv_pixel_feeder.sv
// rtl/conv_pixel_feeder.sv - streams a stored frame into the conv engine; FEEDER_TIMEOUT_EN adds a done watchdog
module conv_pixel_feeder
  import conv_feeder_pkg::*;
#(
  parameter int IMG_WIDTH      = conv_feeder_pkg::IMG_WIDTH,
  parameter int IMG_HEIGHT     = conv_feeder_pkg::IMG_HEIGHT,
  parameter int PIXEL_W        = conv_feeder_pkg::PIXEL_W,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  conv_pixel_feeder_if.master io_feed
);

  localparam int N  = IMG_WIDTH * IMG_HEIGHT;
  localparam int AW = $clog2(N);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  feeder_state_t r_state;
  logic [CW-1:0] r_pix_cnt;
  logic [3:0]    r_gap;
  logic [3:0]    r_gap_cnt;
  logic          r_start;
  logic          r_valid;
  logic          r_busy;
  logic          r_frame_done;

  logic               w_last;
  logic               w_rd_en;
  logic               w_we;
  logic [CW-1:0]      w_next_cnt;
  logic [AW-1:0]      w_rd_addr;
  logic [PIXEL_W-1:0] w_pixel;

`ifdef FEEDER_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);
  logic [WW-1:0] r_wd_cnt;
  logic          r_tmo;
`endif

  // r_pix_cnt is the index of the most recently presented pixel.
  assign w_last     = r_valid && (r_pix_cnt == LAST);
  assign w_next_cnt = r_pix_cnt + 1'b1;
  assign w_rd_en    = (r_state == START) ||
                      ((r_state == STREAM) && (r_gap_cnt == 4'd0) && !w_last);
  assign w_rd_addr  = (r_state == START) ? '0 : w_next_cnt[AW-1:0];
  assign w_we       = io_feed.load_we && (r_state == IDLE) && !rst;

  feeder_frame_ram #(
    .DEPTH  (N),
    .DATA_W (PIXEL_W),
    .AW     (AW)
  ) u_ram (
    .clk      (clk),
    .i_we     (w_we),
    .i_waddr  (io_feed.load_addr),
    .i_wdata  (io_feed.load_data),
    .i_re     (w_rd_en),
    .i_raddr  (w_rd_addr),
    .i_rd_clr (rst),
    .o_rdata  (w_pixel)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_pix_cnt    <= '0;
      r_gap        <= '0;
      r_gap_cnt    <= '0;
      r_start      <= 1'b0;
      r_valid      <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
`ifdef FEEDER_TIMEOUT_EN
      r_wd_cnt     <= '0;
      r_tmo        <= 1'b0;
`endif
    end else begin
      r_start      <= 1'b0;
      r_valid      <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        IDLE: if (io_feed.launch) begin
          r_state   <= START;
          r_start   <= 1'b1;
          r_busy    <= 1'b1;
          r_gap     <= io_feed.gap_cfg;
          r_gap_cnt <= io_feed.gap_cfg;
          r_pix_cnt <= '0;
`ifdef FEEDER_TIMEOUT_EN
          r_tmo     <= 1'b0;
`endif
        end
        START: begin
          r_state   <= STREAM;
          r_valid   <= 1'b1;
          r_pix_cnt <= '0;
          r_gap_cnt <= r_gap;
        end
        STREAM: begin
          if (w_last) begin
            r_state <= WAIT_DONE;
`ifdef FEEDER_TIMEOUT_EN
            r_wd_cnt <= '0;
`endif
          end else if (r_gap_cnt == 4'd0) begin
            r_valid   <= 1'b1;
            r_pix_cnt <= w_next_cnt;
            r_gap_cnt <= r_gap;
          end else begin
            r_gap_cnt <= r_gap_cnt - 4'd1;
          end
        end
        WAIT_DONE: begin
          if (io_feed.engine_done) begin
            r_state      <= FINISH;
            r_frame_done <= 1'b1;
          end
`ifdef FEEDER_TIMEOUT_EN
          else if (r_wd_cnt == WD_LAST) begin
            r_state      <= FINISH;
            r_frame_done <= 1'b1;
            r_tmo        <= 1'b1;
          end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
          end
`endif
        end
        FINISH: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign io_feed.start_signal = r_start;
  assign io_feed.pixel_valid  = r_valid;
  assign io_feed.pixel_out    = w_pixel;
  assign io_feed.busy         = r_busy;
  assign io_feed.frame_done   = r_frame_done;
`ifdef FEEDER_TIMEOUT_EN
  assign io_feed.timeout_err  = r_tmo;
`else
  assign io_feed.timeout_err  = 1'b0;
`endif

endmodule

// File: tb/tb_conv_pixel_feeder.sv
// tb/tb_conv_pixel_feeder.sv - directed self-checking bench for conv_pixel_feeder
module tb_conv_pixel_feeder;
  import conv_feeder_pkg::*;

  localparam int N = FRAME_PIXELS;
`ifdef FEEDER_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_pixel_feeder_if #(.PIXEL_W(PIXEL_W), .ADDR_W(ADDR_W)) feed ();

  conv_pixel_feeder #(
    .IMG_WIDTH      (IMG_WIDTH),
    .IMG_HEIGHT     (IMG_HEIGHT),
    .PIXEL_W        (PIXEL_W),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .io_feed (feed)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [PIXEL_W-1:0] mdl [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_start"},   feed.start_signal, 0);
    chk({tag, "_valid"},   feed.pixel_valid, 0);
    chk({tag, "_pixel"},   feed.pixel_out, 0);
    chk({tag, "_busy"},    feed.busy, 0);
    chk({tag, "_fdone"},   feed.frame_done, 0);
    chk({tag, "_tmo"},     feed.timeout_err, 0);
  endtask

  // rel counts cycles after the launch-accept cycle; pixel k expected at rel 2+k*(g+1).
  task automatic run_frame(input int g, input bit eng, input int abort_k,
                           input bit inject, input bit p0w);
    int k, last_rel, end_rel, fd_cnt, fd_rel;
    bit exp_v;
    logic [PIXEL_W-1:0] last_pix;
    k = 0;
    fd_cnt = 0;
    last_pix = '0;
    last_rel = 2 + (N - 1) * (g + 1);
    fd_rel   = eng ? last_rel + 2 : (TMO ? last_rel + 65 : -1);
    end_rel  = eng ? last_rel + 3 : last_rel + 70;
    @(negedge clk);
    feed.launch  = 1'b1;
    feed.gap_cfg = 4'(g);
    if (p0w) begin
      feed.load_we   = 1'b1;
      feed.load_addr = '0;
      feed.load_data = 8'h7E;
      mdl[0] = 8'h7E;
    end
    @(negedge clk);
    feed.launch  = 1'b0;
    feed.load_we = 1'b0;
    chk("start_pulse", feed.start_signal, 1);
    chk("valid_at_start", feed.pixel_valid, 0);
    chk("busy_at_start", feed.busy, 1);
    chk("tmo_cleared", feed.timeout_err, 0);
    for (int rel = 2; rel <= end_rel; rel++) begin
      @(negedge clk);
      exp_v = (rel <= last_rel) && ((rel - 2) % (g + 1) == 0);
      chk("start_low", feed.start_signal, 0);
      chk("valid", feed.pixel_valid, exp_v);
      if (exp_v) begin
        chk("pixel", feed.pixel_out, mdl[k]);
        last_pix = mdl[k];
        k++;
      end else if (rel <= last_rel) begin
        chk("gap_hold", feed.pixel_out, last_pix);
      end
      chk("frame_done", feed.frame_done, rel == fd_rel);
      chk("busy", feed.busy, (fd_rel < 0) || (rel <= fd_rel));
      chk("timeout_err", feed.timeout_err, TMO && !eng && (rel >= fd_rel));
      fd_cnt += int'(feed.frame_done);
      feed.engine_done = eng && (rel == last_rel + 1);
      feed.launch      = inject && (rel == 20);
      feed.load_we     = inject && (rel == 20);
      feed.load_addr   = 10'd5;
      feed.load_data   = 8'hAA;
      if (exp_v && (k - 1 == abort_k)) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle_outputs("abort");
        return;
      end
    end
    feed.engine_done = 1'b0;
    chk("pixel_count", k, N);
    chk("frame_done_count", fd_cnt, (fd_rel < 0) ? 0 : 1);
  endtask

  initial begin
    feed.load_we     = 1'b0;
    feed.load_addr   = '0;
    feed.load_data   = '0;
    feed.launch      = 1'b0;
    feed.gap_cfg     = '0;
    feed.engine_done = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rst = 1'b0;

    for (int a = 0; a < N; a++) begin
      @(negedge clk);
      feed.load_we   = 1'b1;
      feed.load_addr = 10'(a);
      feed.load_data = 8'(a);
      mdl[a] = 8'(a);
    end
    @(negedge clk);
    feed.load_we = 1'b0;
    chk_idle_outputs("after_load");

    run_frame(0, 1'b1, -1, 1'b0, 1'b0);
    run_frame(3, 1'b1, -1, 1'b1, 1'b0);
    run_frame(0, 1'b1, -1, 1'b0, 1'b0);
    run_frame(1, 1'b1, -1, 1'b0, 1'b1);
    run_frame(0, 1'b1, 300, 1'b0, 1'b0);
    run_frame(0, 1'b1, -1, 1'b0, 1'b0);
    run_frame(0, 1'b0, -1, 1'b0, 1'b0);
    chk("tmo_sticky", feed.timeout_err, TMO);
    if (!TMO) begin
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_idle_outputs("wd_recover");
    end
    run_frame(2, 1'b1, -1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
